// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALU op codes, port widths
// and the controller FSM state encoding.
package alu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int SHAMT_W  = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;

    // Op codes at or above this value have no ALU meaning and raise resp_err.
    localparam logic [ALU_OP_W-1:0] ALU_FIRST_ILLEGAL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: starting one past the last winner, picks
// the first asserted request (wrapping) and returns it one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int RW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [RW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [RW-1:0]      gnt_idx,
    output logic               gnt_valid
);

    // Search upward from ptr+1 and keep the first hit only.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_idx   = RW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one single-cycle ALU between NUM_REQ requesters. One operation is in
// flight at a time: IDLE (arbitrate + capture) -> EXEC (drive ALU, register
// result) -> RESP (hold response until the owner accepts it).
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int RW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op,
    input  logic [DATA_W*NUM_REQ-1:0]    req_a,
    input  logic [DATA_W*NUM_REQ-1:0]    req_b,
    input  logic [SHAMT_W*NUM_REQ-1:0]   req_shamt,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [DATA_W-1:0]            resp_result,
    output logic                         resp_zero,
    output logic                         resp_err,
    output logic [ALU_OP_W-1:0]          alu_cnt,
    output logic [DATA_W-1:0]            alu_in1,
    output logic [DATA_W-1:0]            alu_in2,
    output logic [SHAMT_W-1:0]           alu_shamt,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic                         alu_zero
);

    state_e               state_q, state_d;
    logic [RW-1:0]        ptr_q, ptr_d;
    logic [RW-1:0]        id_q, id_d;
    logic [ALU_OP_W-1:0]  op_q, op_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    b_q, b_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]    resp_result_q, resp_result_d;
    logic                 resp_zero_q, resp_zero_d;
    logic                 resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [RW-1:0]        gnt_idx;
    logic                 gnt_valid;
    logic [ALU_OP_W-1:0]  sel_op;
    logic [DATA_W-1:0]    sel_a, sel_b;
    logic [SHAMT_W-1:0]   sel_shamt;
    logic                 op_illegal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RW      (RW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Accept only while idle; the grant already implies the request is valid.
    assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

    // Pick the granted requester's payload out of the packed request buses.
    always_comb begin
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_shamt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_op    = req_op[ALU_OP_W*i +: ALU_OP_W];
                sel_a     = req_a[DATA_W*i +: DATA_W];
                sel_b     = req_b[DATA_W*i +: DATA_W];
                sel_shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
            end
        end
    end

    assign op_illegal = (op_q >= ALU_FIRST_ILLEGAL);

    // The ALU sees the captured operation only during EXEC; an illegal op is
    // presented as op 0 so the ALU never decodes an undefined code.
    assign alu_cnt   = (state_q == ST_EXEC && !op_illegal) ? op_q : '0;
    assign alu_in1   = (state_q == ST_EXEC) ? a_q     : '0;
    assign alu_in2   = (state_q == ST_EXEC) ? b_q     : '0;
    assign alu_shamt = (state_q == ST_EXEC) ? shamt_q : '0;

    // Next-state and next-register values for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        shamt_d       = shamt_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = ST_EXEC;
                    ptr_d   = gnt_idx;
                    id_d    = gnt_idx;
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    shamt_d = sel_shamt;
                end
            end
            ST_EXEC: begin
                state_d              = ST_RESP;
                resp_valid_d         = '0;
                resp_valid_d[id_q]   = 1'b1;
                resp_result_d        = op_illegal ? '0   : alu_result;
                resp_zero_d          = op_illegal ? 1'b0 : alu_zero;
                resp_err_d           = op_illegal;
            end
            ST_RESP: begin
                // Only the owner's resp_ready can retire the response.
                if (resp_ready[id_q]) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = '0;
            end
        endcase
    end

    // State registers; the pointer starts at the last requester so index 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= RW'(NUM_REQ - 1);
            id_q          <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            shamt_q       <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its _d input, independent of statement order.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            shamt_q       <= shamt_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_err    = resp_err_q;

endmodule
